// File: rtl/d3_word_splitter_if.sv
// ============================================================================
// Module   : d3_word_splitter_if
// Purpose  : Word-in / half-word-out stream bundle for the d3 word splitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface d3_word_splitter_if #(
  parameter int g_w3    = 16,
  parameter int g_cnt_w = 8
);
  logic [2*g_w3-1:0]  d3;
  logic               d3_valid;
  logic               d3_ready;
  logic [g_w3-1:0]    q;
  logic               q_valid;
  logic               q_ready;
  logic               q_last;
  logic [g_cnt_w-1:0] word_cnt;

  // Splitter side: consumes d3, produces q.
  modport slave (
    input  d3, d3_valid, q_ready,
    output d3_ready, q, q_valid, q_last, word_cnt
  );

  // Environment side: produces d3, consumes q.
  modport master (
    output d3, d3_valid, q_ready,
    input  d3_ready, q, q_valid, q_last, word_cnt
  );
endinterface

`default_nettype wire

// File: rtl/d3_word_splitter.sv
// ============================================================================
// Module   : d3_word_splitter
// Purpose  : Serialises each 2*g_w3-bit d3 word into two g_w3-bit halves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d3_word_splitter #(
  parameter int g_w3        = 16,
  parameter bit g_lsb_first = 1'b1,
  parameter int g_cnt_w     = 8
) (
  input  wire                  clk,
  input  wire                  rst_n,
  d3_word_splitter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  state_t             r_state;
  logic [g_w3-1:0]    r_hold;
  logic [g_w3-1:0]    r_q;
  logic               r_q_valid;
  logic               r_q_last;
  logic [g_cnt_w-1:0] r_word_cnt;

  logic [g_w3-1:0]    w_in_first;
  logic [g_w3-1:0]    w_in_second;
  logic               w_d3_ready;

  if (g_lsb_first) begin : g_lsb_order
    assign w_in_first  = bus.d3[g_w3-1:0];
    assign w_in_second = bus.d3[2*g_w3-1:g_w3];
  end else begin : g_msb_order
    assign w_in_first  = bus.d3[2*g_w3-1:g_w3];
    assign w_in_second = bus.d3[g_w3-1:0];
  end

  // Ready looks only at state and downstream ready, never at d3_valid.
  assign w_d3_ready = (r_state == ST_EMPTY) ||
                      ((r_state == ST_SECOND) && bus.q_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_hold     <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_q_last   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (bus.d3_valid) begin
            r_hold    <= w_in_second;
            r_q       <= w_in_first;
            r_q_last  <= 1'b0;
            r_q_valid <= 1'b1;
            r_state   <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (bus.q_ready) begin
            r_q      <= r_hold;
            r_q_last <= 1'b1;
            r_state  <= ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (bus.q_ready) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            // Back-to-back word: reload directly so there is no idle cycle.
            if (bus.d3_valid) begin
              r_hold   <= w_in_second;
              r_q      <= w_in_first;
              r_q_last <= 1'b0;
              r_state  <= ST_FIRST;
            end else begin
              r_q_valid <= 1'b0;
              r_q_last  <= 1'b0;
              r_state   <= ST_EMPTY;
            end
          end
        end
        default: begin
          r_q_valid <= 1'b0;
          r_q_last  <= 1'b0;
          r_state   <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.d3_ready = w_d3_ready;
  assign bus.q        = r_q;
  assign bus.q_valid  = r_q_valid;
  assign bus.q_last   = r_q_last;
  assign bus.word_cnt = r_word_cnt;

endmodule

`default_nettype wire
